sort_drain: RTL and testbench

SORT_DRAIN -- requirements
Module: sort_drain

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_order_chk.sv | 30 +++
 rtl/sort_drain.sv | 124 ++++++++++++
 tb/tb_sort_drain.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the sorted-frame drain block.
package sort_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_N     = 6;
    localparam int DEF_WIDTH = 8;

    // Width of an index into an N-entry frame (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sort_order_chk.sv
// Ordering monitor: flags any handshaken entry smaller than the previous one of the same frame.
module sort_order_chk #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             handshake,
    input  logic             first,
    input  logic [WIDTH-1:0] data,
    output logic             err
);

    logic [WIDTH-1:0] prev_reg;
    logic             err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= '0;
            err_reg  <= 1'b0;
        end else if (handshake) begin
            prev_reg <= data;
            if (!first && (data < prev_reg)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;

endmodule

// File: rtl/sort_drain.sv
// Holds one sorted frame and streams it out entry by entry over a valid/ready port.
// Optional ordering checker (order_err port) enabled by defining SORT_DRAIN_CHECK_EN.
module sort_drain
    import sort_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH-1:0]       data_in [N],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [idx_w(N)-1:0]    out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overrun
`ifdef SORT_DRAIN_CHECK_EN
    ,
    output logic                   order_err
`endif
);

    localparam int             IW       = idx_w(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    state_t           state_reg, state_next;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic             overrun_reg, overrun_next;
    logic             capture;
    logic             hs;
    logic             at_last;
    logic [WIDTH-1:0] buf_reg [N];

    assign hs      = out_valid && out_ready;
    assign at_last = (ptr_reg == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            overrun_reg <= overrun_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                buf_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N; i++) begin
                buf_reg[i] <= data_in[i];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        overrun_next = overrun_reg;
        capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    capture      = 1'b1;
                    ptr_next     = '0;
                    overrun_next = 1'b0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                if (hs && at_last) begin
                    // Final entry accepted: a coincident load chains straight into the next frame.
                    if (load) begin
                        capture      = 1'b1;
                        ptr_next     = '0;
                        overrun_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (hs) begin
                        ptr_next = ptr_reg + 1'b1;
                    end
                    if (load) begin
                        overrun_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; in IDLE ptr and buffer are untouched so data/idx hold.
    assign out_valid = (state_reg == SEND);
    assign busy      = (state_reg == SEND);
    assign out_data  = buf_reg[ptr_reg];
    assign out_idx   = ptr_reg;
    assign out_last  = out_valid && at_last;
    assign overrun   = overrun_reg;

`ifdef SORT_DRAIN_CHECK_EN
    sort_order_chk #(
        .WIDTH(WIDTH)
    ) u_order_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .handshake (hs),
        .first     (ptr_reg == '0),
        .data      (out_data),
        .err       (order_err)
    );
`endif

endmodule

// File: tb/tb_sort_drain.sv
// Self-checking bench for sort_drain: table vectors, directed corner sequences, random traffic vs a queue model.
module tb_sort_drain;
    localparam int N = 6;
    localparam int W = 8;

    typedef logic [N-1:0][W-1:0] frame_t;
    typedef struct packed {
        logic         ld;
        logic         rdy;
        frame_t       fr;
        logic         e_valid;
        logic [W-1:0] e_data;
        logic [2:0]   e_idx;
        logic         e_last;
        logic         e_busy;
        logic         e_ovr;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in [N];
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         overrun;
`ifdef SORT_DRAIN_CHECK_EN
    logic         order_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of entries still to be delivered, plus the value shown when idle.
    int q_d[$];
    int q_i[$];
    int hold_d = 0;
    int hold_i = 0;
    bit m_ovr  = 1'b0;
    bit m_oerr = 1'b0;
    int prev_hs = 0;

    always #5 clk = ~clk;

    sort_drain #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SORT_DRAIN_CHECK_EN
        ,
        .order_err (order_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_d.delete();
        q_i.delete();
        hold_d  = 0;
        hold_i  = 0;
        m_ovr   = 1'b0;
        m_oerr  = 1'b0;
        prev_hs = 0;
    endtask

    task automatic model_step(input logic ld, input logic rdy, input frame_t fr);
        bit hs;
        hs = rdy && (q_d.size() > 0);
        if (hs) begin
            if (q_i[0] > 0 && q_d[0] < prev_hs) m_oerr = 1'b1;
            prev_hs = q_d[0];
            hold_d  = q_d.pop_front();
            hold_i  = q_i.pop_front();
        end
        if (ld) begin
            if (q_d.size() == 0) begin
                for (int i = 0; i < N; i++) begin
                    q_d.push_back(int'(fr[i]));
                    q_i.push_back(i);
                end
                m_ovr = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        bit v;
        v = (q_d.size() > 0);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(v));
        chk({tag, ".data"}, 32'(out_data), v ? 32'(q_d[0]) : 32'(hold_d));
        chk({tag, ".idx"}, 32'(out_idx), v ? 32'(q_i[0]) : 32'(hold_i));
        chk({tag, ".last"}, 32'(out_last), 32'(v && q_i[0] == N - 1));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
`ifdef SORT_DRAIN_CHECK_EN
        chk({tag, ".order_err"}, 32'(order_err), 32'(m_oerr));
`endif
    endtask

    // Drive inputs for one clock, then compare against the model just after the edge.
    task automatic cycle(input string tag, input logic ld, input logic rdy, input frame_t fr);
        load      = ld;
        out_ready = rdy;
        for (int i = 0; i < N; i++) data_in[i] = fr[i];
        @(posedge clk);
        #1;
        model_step(ld, rdy, fr);
        check_model(tag);
        load = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        int v;
        v = $urandom_range(0, 30);
        for (int i = 0; i < N; i++) begin
            f[i] = W'(v);
            v += $urandom_range(0, 30);
        end
        return f;
    endfunction

    initial begin
        frame_t f_a, f_b, f_c, f_z;
        vec_t   tbl[7];
        f_a = {8'd13, 8'd11, 8'd9, 8'd7, 8'd5, 8'd3};
        f_b = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        f_c = {8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7};
        f_z = '0;
        for (int i = 0; i < N; i++) data_in[i] = '0;

        tbl[0] = '{1'b1, 1'b1, f_a, 1'b1, 8'd3,  3'd0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, f_z, 1'b1, 8'd5,  3'd1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, f_z, 1'b1, 8'd7,  3'd2, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, f_z, 1'b1, 8'd9,  3'd3, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, f_z, 1'b1, 8'd11, 3'd4, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, f_z, 1'b1, 8'd13, 3'd5, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, f_z, 1'b0, 8'd13, 3'd5, 1'b0, 1'b0, 1'b0};

        // Power-on reset values
        #2;
        model_reset();
        check_model("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Full-speed drain from a table of expected outputs
        for (int r = 0; r < 7; r++) begin
            cycle("tbl", tbl[r].ld, tbl[r].rdy, tbl[r].fr);
            chk("tbl.valid", 32'(out_valid), 32'(tbl[r].e_valid));
            chk("tbl.data", 32'(out_data), 32'(tbl[r].e_data));
            chk("tbl.idx", 32'(out_idx), 32'(tbl[r].e_idx));
            chk("tbl.last", 32'(out_last), 32'(tbl[r].e_last));
            chk("tbl.busy", 32'(busy), 32'(tbl[r].e_busy));
            chk("tbl.overrun", 32'(overrun), 32'(tbl[r].e_ovr));
            $display("tbl row %0d: valid=%0d data=%0d idx=%0d last=%0d", r, out_valid, out_data, out_idx, out_last);
        end

        // Stalled drain: ready pattern 1,0,0 repeating
        cycle("stall", 1'b1, 1'b0, f_a);
        for (int c = 0; c < 18; c++) begin
            cycle("stall", 1'b0, (c % 3) == 0, f_z);
            $display("stall cyc %0d: valid=%0d data=%0d idx=%0d", c, out_valid, out_data, out_idx);
        end
        chk("stall.drained", 32'(busy), 32'd0);

        // Back-to-back frames: new load coincident with final handshake
        cycle("b2b", 1'b1, 1'b0, f_b);
        for (int c = 0; c < 5; c++) cycle("b2b", 1'b0, 1'b1, f_z);
        chk("b2b.at_last", 32'(out_data), 32'd6);
        cycle("b2b", 1'b1, 1'b1, f_c);
        chk("b2b.no_gap_data", 32'(out_data), 32'd7);
        chk("b2b.no_gap_valid", 32'(out_valid), 32'd1);
        $display("b2b: data=%0d valid=%0d idx=%0d", out_data, out_valid, out_idx);
        for (int c = 0; c < 6; c++) cycle("b2b", 1'b0, 1'b1, f_z);

        // Overrun while ptr=2
        cycle("ovr", 1'b1, 1'b0, f_b);
        cycle("ovr", 1'b0, 1'b1, f_z);
        cycle("ovr", 1'b0, 1'b1, f_z);
        cycle("ovr", 1'b1, 1'b0, f_c);
        chk("ovr.flag", 32'(overrun), 32'd1);
        chk("ovr.kept", 32'(out_data), 32'd3);
        $display("ovr: overrun=%0d data=%0d idx=%0d", overrun, out_data, out_idx);
        for (int c = 0; c < 4; c++) cycle("ovr", 1'b0, 1'b1, f_z);
        chk("ovr.still_set", 32'(overrun), 32'd1);
        cycle("ovr", 1'b1, 1'b0, f_c);
        chk("ovr.cleared", 32'(overrun), 32'd0);
        for (int c = 0; c < 6; c++) cycle("ovr", 1'b0, 1'b1, f_z);

        // Asynchronous reset while ptr=3
        cycle("arst", 1'b1, 1'b0, f_a);
        for (int c = 0; c < 3; c++) cycle("arst", 1'b0, 1'b1, f_z);
        chk("arst.ptr3", 32'(out_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("arst.now");
        $display("arst: valid=%0d data=%0d idx=%0d busy=%0d", out_valid, out_data, out_idx, busy);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) cycle("arst.after", 1'b0, 1'b1, f_z);

        // Random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            cycle("rand", $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0, rand_frame());
            $display("rand cyc %0d: valid=%0d data=%0d idx=%0d ovr=%0d", c, out_valid, out_data, out_idx, overrun);
        end

`ifdef SORT_DRAIN_CHECK_EN
        hard_reset();
        cycle("oerr", 1'b1, 1'b0, {8'd7, 8'd6, 8'd5, 8'd3, 8'd4, 8'd2});
        cycle("oerr", 1'b0, 1'b1, f_z);
        cycle("oerr", 1'b0, 1'b1, f_z);
        chk("oerr.before", 32'(order_err), 32'd0);
        cycle("oerr", 1'b0, 1'b1, f_z);
        chk("oerr.after3", 32'(order_err), 32'd1);
        for (int c = 0; c < 4; c++) cycle("oerr", 1'b0, 1'b1, f_z);
        hard_reset();
        cycle("oeq", 1'b1, 1'b0, {8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd2});
        for (int c = 0; c < 7; c++) cycle("oeq", 1'b0, 1'b1, f_z);
        chk("oeq.clear", 32'(order_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
